// File: rtl/vga_glyph_writer.sv
// Glyph loader: streams one glyph's 16-bit words into the character RAM,
// writing only while the display opens the write window (vertical blanking).
module vga_glyph_writer #(
   parameter int unsigned WORDS_PER_GLYPH = 48,
   parameter int unsigned ADDR_W          = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [15:0]       data_word,
   input  logic              write_window,
   input  logic              abort,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [15:0]       bram_d,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam int unsigned IDX_W  = 6;
   localparam int unsigned DATA_W = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_GLYPH - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_reg, base_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic                we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   d_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                aborted_nxt;
   logic                xfer;

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base_reg  <= '0;
         idx       <= '0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_d    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nxt;
         base_reg  <= base_nxt;
         idx       <= idx_nxt;
         bram_we   <= we_nxt;
         bram_addr <= addr_nxt;
         bram_d    <= d_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         aborted   <= aborted_nxt;
      end
   end

   // Next-state, handshakes and next values of the registered outputs
   always_comb begin
      state_nxt   = state;
      base_nxt    = base_reg;
      idx_nxt     = idx;
      we_nxt      = 1'b0;
      addr_nxt    = bram_addr;
      d_nxt       = bram_d;
      done_nxt    = 1'b0;
      aborted_nxt = 1'b0;
      cmd_ready   = (state == IDLE);
      data_ready  = (state == WRITE) && write_window && !abort;
      xfer        = data_valid && data_ready;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               base_nxt  = cmd_base;
               idx_nxt   = '0;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_nxt   = IDLE;
               aborted_nxt = 1'b1;
            end else if (xfer) begin
               we_nxt   = 1'b1;
               // Address wraps naturally at the RAM size
               addr_nxt = base_reg + ADDR_W'(idx);
               d_nxt    = data_word;
               idx_nxt  = idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_vga_glyph_writer.sv
// Scoreboard bench for vga_glyph_writer: a reference model predicts each RAM
// write as stimulus is driven; a monitor pops and compares the actual writes.
module tb_vga_glyph_writer;

   localparam int unsigned ADDR_W = 10;
   localparam int S_IDLE  = 0;
   localparam int S_WRITE = 1;
   localparam int S_DONE  = 2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       d;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base = '0;
   logic              data_valid = 1'b0;
   logic              data_ready;
   logic [15:0]       data_word = '0;
   logic              write_window = 1'b0;
   logic              abort = 1'b0;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [15:0]       bram_d;
   logic              busy;
   logic              done;
   logic              aborted;

   vga_glyph_writer dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_base     (cmd_base),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .data_word    (data_word),
      .write_window (write_window),
      .abort        (abort),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_d       (bram_d),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state and expectations for the cycle after the next edge
   int                m_state = S_IDLE;
   logic [ADDR_W-1:0] m_base  = '0;
   int                m_idx   = 0;
   logic              exp_we = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_aborted = 1'b0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [15:0]       last_d = '0;
   exp_t              sb[$];
   int                writes = 0, done_cnt = 0, aborted_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Registered outputs are sampled just after each rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      check("bram_we", 32'(bram_we), 32'(exp_we));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("aborted", 32'(aborted), 32'(exp_aborted));
      if (done) done_cnt++;
      if (aborted) aborted_cnt++;
      if (bram_we) begin
         writes++;
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(1), 32'(0));
         end else begin
            e = sb.pop_front();
            check("bram_addr", 32'(bram_addr), 32'(e.addr));
            check("bram_d", 32'(bram_d), 32'(e.d));
            last_addr = e.addr;
            last_d    = e.d;
         end
      end else begin
         check("hold_addr", 32'(bram_addr), 32'(last_addr));
         check("hold_d", 32'(bram_d), 32'(last_d));
      end
   end

   // One cycle: inputs already set at a falling edge; check handshakes, advance model
   task automatic tick(output bit xferred);
      exp_t e;
      #1;
      check("cmd_ready", 32'(cmd_ready), 32'(m_state == S_IDLE));
      check("data_ready", 32'(data_ready),
            32'(m_state == S_WRITE && write_window && !abort));
      xferred     = 1'b0;
      exp_we      = 1'b0;
      exp_done    = 1'b0;
      exp_aborted = 1'b0;
      if (!reset) begin
         case (m_state)
            S_IDLE: if (cmd_valid) begin
               m_base  = cmd_base;
               m_idx   = 0;
               m_state = S_WRITE;
            end
            S_WRITE: if (abort) begin
               m_state     = S_IDLE;
               exp_aborted = 1'b1;
            end else if (write_window && data_valid) begin
               e.addr = ADDR_W'(int'(m_base) + m_idx);
               e.d    = data_word;
               sb.push_back(e);
               exp_we  = 1'b1;
               xferred = 1'b1;
               if (m_idx == 47) begin
                  m_state  = S_DONE;
                  exp_done = 1'b1;
               end
               m_idx++;
            end
            default: m_state = S_IDLE;
         endcase
      end
      exp_busy = (m_state != S_IDLE);
      @(negedge clk);
   endtask

   task automatic clear_counts();
      writes = 0;
      done_cnt = 0;
      aborted_cnt = 0;
   endtask

   // Issue one glyph load; optionally stop early, open a window gap, stall the source,
   // and offer the next command already during the DONE cycle.
   task automatic load(input logic [ADDR_W-1:0] base, input logic [15:0] seed,
                       input int stop_after, input int gap_after, input int gap_len,
                       input int stall_pct, input bit next_cmd,
                       input logic [ADDR_W-1:0] next_base);
      int w = 0;
      int gap_left = gap_len;
      int guard = 0;
      bit x;
      cmd_valid    = 1'b1;
      cmd_base     = base;
      data_valid   = 1'b0;
      write_window = 1'b1;
      abort        = 1'b0;
      tick(x);
      cmd_valid = 1'b0;
      while (m_state == S_WRITE && w != stop_after && guard < 2000) begin
         write_window = !(w == gap_after && gap_left > 0);
         if (!write_window) gap_left--;
         data_valid = (int'($urandom_range(99)) >= stall_pct);
         data_word  = seed + 16'(w);
         tick(x);
         if (x) w++;
         guard++;
      end
      if (guard >= 2000) check("load_timeout", 32'(1), 32'(0));
      data_valid = 1'b0;
      if (m_state == S_DONE) begin
         cmd_valid = next_cmd;
         cmd_base  = next_base;
         tick(x);
      end
   endtask

   initial begin
      bit x;
      @(negedge clk);
      check("rst_bram_we", 32'(bram_we), 32'(0));
      check("rst_bram_addr", 32'(bram_addr), 32'(0));
      check("rst_bram_d", 32'(bram_d), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_aborted", 32'(aborted), 32'(0));
      reset = 1'b0;
      tick(x);

      // Basic load, words 0x0000..0x002F at addresses 0..47
      clear_counts();
      load(10'd0, 16'h0000, -1, -1, 0, 0, 1'b0, '0);
      check("basic_writes", 32'(writes), 32'(48));
      check("basic_done_cnt", 32'(done_cnt), 32'(1));

      // Window drops for 10 cycles after word 20
      clear_counts();
      load(10'd128, 16'h0100, -1, 21, 10, 0, 1'b0, '0);
      check("gap_writes", 32'(writes), 32'(48));
      check("gap_done_cnt", 32'(done_cnt), 32'(1));

      // Address wrap from 1020
      clear_counts();
      load(10'd1020, 16'h0200, -1, -1, 0, 0, 1'b0, '0);
      check("wrap_writes", 32'(writes), 32'(48));
      check("wrap_last_addr", 32'(last_addr), 32'(43));

      // Abort after word 10; abort in IDLE is then ignored
      clear_counts();
      load(10'd200, 16'h1000, 11, -1, 0, 0, 1'b0, '0);
      abort = 1'b1;
      data_valid = 1'b1;
      tick(x);
      abort = 1'b0;
      data_valid = 1'b0;
      tick(x);
      abort = 1'b1;
      tick(x);
      abort = 1'b0;
      tick(x);
      check("abort_writes", 32'(writes), 32'(11));
      check("abort_pulses", 32'(aborted_cnt), 32'(1));
      check("abort_done_cnt", 32'(done_cnt), 32'(0));

      // Asynchronous reset between edges after word 5
      clear_counts();
      load(10'd400, 16'h0500, 6, -1, 0, 0, 1'b0, '0);
      check("pre_rst_we", 32'(bram_we), 32'(1));
      reset = 1'b1;
      #1;
      check("async_rst_we", 32'(bram_we), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      m_state = S_IDLE;
      exp_we = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_aborted = 1'b0;
      last_addr = '0;
      last_d = '0;
      check("rst_sb_empty", 32'(sb.size()), 32'(0));
      sb.delete();
      data_valid = 1'b0;
      tick(x);
      tick(x);
      reset = 1'b0;
      tick(x);
      clear_counts();
      load(10'd400, 16'h0600, -1, -1, 0, 0, 1'b0, '0);
      check("post_rst_writes", 32'(writes), 32'(48));
      check("post_rst_done_cnt", 32'(done_cnt), 32'(1));
      check("post_rst_aborted", 32'(aborted_cnt), 32'(0));

      // Back-to-back commands with random source stalls
      clear_counts();
      load(10'd300, 16'h2000, -1, -1, 0, 30, 1'b1, 10'd700);
      load(10'd700, 16'h3000, -1, -1, 0, 30, 1'b0, '0);
      tick(x);
      check("b2b_writes", 32'(writes), 32'(96));
      check("b2b_done_cnt", 32'(done_cnt), 32'(2));

      tick(x);
      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
